// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
// Arms on request, fills a pre-trigger window into a circular capture buffer,
// waits for a level crossing or software trigger, fills the post-trigger
// window, then streams the whole buffer out oldest-first over valid/ready.
module adc_capture_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  adc_clock,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_falling,
  input  logic                  sw_trigger,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    READOUT,
    DONE
  } state_t;

  // Readout handshake phases: present the first address, capture the
  // buffer's registered read data, then hold the sample until accepted.
  typedef enum logic [1:0] {
    RD_ISSUE,
    RD_CAPTURE,
    RD_HOLD
  } rd_phase_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                  state;
  state_t                  next_state;
  rd_phase_t               rd_phase;

  logic [ADDR_WIDTH-1:0]   wptr;
  logic [ADDR_WIDTH-1:0]   rptr;
  logic [ADDR_WIDTH-1:0]   p_reg;
  logic [ADDR_WIDTH-1:0]   pre_cnt;
  logic [ADDR_WIDTH-1:0]   post_cnt;
  logic [ADDR_WIDTH-1:0]   rd_cnt;
  logic [DATA_WIDTH-1:0]   level_reg;
  logic [DATA_WIDTH-1:0]   prev;
  logic                    falling_reg;
  logic                    prev_valid;

  logic                    level_hit;
  logic                    trigger;
  logic                    accept;

  // Write port follows the write pointer; data is gated so it reads zero
  // whenever no write is in progress.
  assign buf_waddr = wptr;
  assign buf_wdata = buf_we ? adc_data : '0;
  assign buf_raddr = rptr;

  // Trigger detection: unsigned level crossing against the previous sample,
  // which only counts once a previous sample exists; software trigger always.
  always_comb begin
    level_hit = 1'b0;
    if (prev_valid) begin
      if (falling_reg) begin
        level_hit = (prev > level_reg) && (adc_data <= level_reg);
      end else begin
        level_hit = (prev < level_reg) && (adc_data >= level_reg);
      end
    end
    trigger = sw_trigger || level_hit;
    accept  = out_valid && out_ready;
  end

  // State register.
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived outputs; abort overrides everything.
  always_comb begin
    next_state = state;
    buf_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      PRE, ARMED, POST: begin
        buf_we = 1'b1;
        busy   = 1'b1;
      end
      READOUT: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase

    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            next_state = (pretrig_len == '0) ? ARMED : PRE;
          end
        end
        PRE: begin
          if (pre_cnt == ADDR_ONE) begin
            next_state = ARMED;
          end
        end
        ARMED: begin
          if (trigger) begin
            next_state = (p_reg == ADDR_MAX) ? READOUT : POST;
          end
        end
        POST: begin
          if (post_cnt == ADDR_ONE) begin
            next_state = READOUT;
          end
        end
        READOUT: begin
          if (accept && out_last) begin
            next_state = DONE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Capture side: configuration latch on arm, write pointer, previous-sample
  // tracking, window counters and the trigger address.
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      p_reg       <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      level_reg   <= '0;
      falling_reg <= 1'b0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      trig_addr   <= '0;
    end else if (!abort) begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            p_reg       <= pretrig_len;
            pre_cnt     <= pretrig_len;
            level_reg   <= trig_level;
            falling_reg <= trig_falling;
            wptr        <= '0;
            prev_valid  <= 1'b0;
          end
        end
        PRE: begin
          wptr       <= wptr + ADDR_ONE;
          pre_cnt    <= pre_cnt - ADDR_ONE;
          prev       <= adc_data;
          prev_valid <= 1'b1;
        end
        ARMED: begin
          wptr       <= wptr + ADDR_ONE;
          prev       <= adc_data;
          prev_valid <= 1'b1;
          if (trigger) begin
            trig_addr <= wptr;
            post_cnt  <= ~p_reg;
          end
        end
        POST: begin
          wptr     <= wptr + ADDR_ONE;
          post_cnt <= post_cnt - ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

  // Readout side: read pointer runs one address ahead of the held sample so
  // the buffer's one-cycle read latency is hidden after each acceptance.
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      rptr      <= '0;
      rd_cnt    <= '0;
      rd_phase  <= RD_ISSUE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (abort) begin
      rd_phase  <= RD_ISSUE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (state == ARMED && trigger) begin
      rptr     <= wptr - p_reg;
      rd_cnt   <= '0;
      rd_phase <= RD_ISSUE;
    end else if (state == READOUT) begin
      case (rd_phase)
        RD_ISSUE: begin
          rptr     <= rptr + ADDR_ONE;
          rd_phase <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          out_data  <= buf_rdata;
          out_valid <= 1'b1;
          out_last  <= (rd_cnt == ADDR_MAX);
          rd_phase  <= RD_HOLD;
        end
        RD_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_cnt    <= rd_cnt + ADDR_ONE;
            rptr      <= rptr + ADDR_ONE;
            rd_phase  <= RD_CAPTURE;
          end
        end
        default: rd_phase <= RD_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer
// Directed bench for the capture sequencer with a 16-entry buffer model.
module tb_adc_capture_sequencer;

  localparam int DW = 12;
  localparam int AW = 4;

  logic          adc_clock;
  logic          reset;
  logic          arm;
  logic          abort;
  logic [DW-1:0] trig_level;
  logic          trig_falling;
  logic          sw_trigger;
  logic [AW-1:0] pretrig_len;
  logic [DW-1:0] adc_data;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [DW-1:0] buf_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          done;

  int tests_run;
  int tests_failed;

  int   got_data[16];
  logic got_last[16];
  int   got_n;
  int   exp_data[16];

  logic [DW-1:0] mem[16];

  adc_capture_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .adc_clock   (adc_clock),
    .reset       (reset),
    .arm         (arm),
    .abort       (abort),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .sw_trigger  (sw_trigger),
    .pretrig_len (pretrig_len),
    .adc_data    (adc_data),
    .buf_we      (buf_we),
    .buf_waddr   (buf_waddr),
    .buf_wdata   (buf_wdata),
    .buf_raddr   (buf_raddr),
    .buf_rdata   (buf_rdata),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .trig_addr   (trig_addr),
    .busy        (busy),
    .done        (done)
  );

  // Free-running sample clock.
  initial adc_clock = 1'b0;
  always #5 adc_clock = ~adc_clock;

  // Capture buffer model: synchronous write, registered read.
  always @(posedge adc_clock) begin
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    buf_rdata <= mem[buf_raddr];
  end

  task automatic tick();
    @(posedge adc_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input logic arm_v,
                               input logic sw_v, input logic abort_v);
    adc_data   = data;
    arm        = arm_v;
    sw_trigger = sw_v;
    abort      = abort_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag);
    int c;
    c = 0;
    while (out_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    checkOutput(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic collectStream(input int budget);
    int c;
    c = 0;
    got_n = 0;
    for (int i = 0; i < 16; i++) begin
      got_data[i] = -1;
      got_last[i] = 1'b0;
    end
    while (got_n < 16 && c < budget) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_data[got_n] = int'(out_data);
        got_last[got_n] = out_last;
        got_n++;
      end
      tick();
      c++;
    end
  endtask

  task automatic checkStream(input string tag);
    checkOutput({tag, "_count"}, got_n, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]},
                  (i == 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"}, {31'd0, buf_we}, 0);
    checkOutput({tag, "_waddr"}, {28'd0, buf_waddr}, 0);
    checkOutput({tag, "_wdata"}, {20'd0, buf_wdata}, 0);
    checkOutput({tag, "_raddr"}, {28'd0, buf_raddr}, 0);
    checkOutput({tag, "_odata"}, {20'd0, out_data}, 0);
    checkOutput({tag, "_ovalid"}, {31'd0, out_valid}, 0);
    checkOutput({tag, "_olast"}, {31'd0, out_last}, 0);
    checkOutput({tag, "_taddr"}, {28'd0, trig_addr}, 0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
    checkOutput({tag, "_done"}, {31'd0, done}, 0);
  endtask

  // Directed scenario sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    out_ready    = 1'b0;
    trig_level   = '0;
    trig_falling = 1'b0;
    pretrig_len  = '0;
    applyStimulus(12'd5, 1'b0, 1'b0, 1'b0);
    #12;
    checkAllZero("reset");
    @(posedge adc_clock);
    #1;
    reset = 1'b0;
    tick();

    // Rising trigger at 100 with four pre-trigger samples, slow consumer.
    pretrig_len  = 4'd4;
    trig_level   = 12'd100;
    trig_falling = 1'b0;
    applyStimulus(12'd0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 22; k++) begin
      applyStimulus(DW'(10 * k), 1'b0, 1'b0, 1'b0);
      #1;
      if (k == 0) begin
        checkOutput("t1_busy", {31'd0, busy}, 1);
        checkOutput("t1_we", {31'd0, buf_we}, 1);
      end
      if (k == 10) begin
        checkOutput("t1_trig_waddr", {28'd0, buf_waddr}, 10);
        checkOutput("t1_trig_wdata", {20'd0, buf_wdata}, 100);
      end
      if (k == 16) checkOutput("t1_wrap", {28'd0, buf_waddr}, 0);
      tick();
    end
    checkOutput("t1_trig_addr", {28'd0, trig_addr}, 10);
    checkOutput("t1_readout_we", {31'd0, buf_we}, 0);
    checkOutput("t1_first_raddr", {28'd0, buf_raddr}, 6);
    waitValid("t5_valid");
    checkOutput("t5_first", {20'd0, out_data}, 60);
    for (int h = 0; h < 5; h++) begin
      tick();
      checkOutput("t5_hold_valid", {31'd0, out_valid}, 1);
      checkOutput("t5_hold_data", {20'd0, out_data}, 60);
    end
    out_ready = 1'b1;
    collectStream(100);
    for (int i = 0; i < 16; i++) exp_data[i] = 60 + 10 * i;
    checkStream("t1");
    checkOutput("t1_done", {31'd0, done}, 1);
    checkOutput("t1_idle_busy", {31'd0, busy}, 0);

    // Zero pre-trigger, software trigger on the first armed cycle.
    pretrig_len = 4'd0;
    applyStimulus(12'd0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(12'd7, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("t2_waddr", {28'd0, buf_waddr}, 0);
    checkOutput("t2_wdata", {20'd0, buf_wdata}, 7);
    tick();
    for (int k = 1; k < 16; k++) begin
      applyStimulus(DW'(100 + k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("t2_trig_addr", {28'd0, trig_addr}, 0);
    collectStream(100);
    exp_data[0] = 7;
    for (int i = 1; i < 16; i++) exp_data[i] = 100 + i;
    checkStream("t2");
    checkOutput("t2_done", {31'd0, done}, 1);

    // Full pre-trigger window, crossing at address 3, no post window.
    pretrig_len = 4'd15;
    trig_level  = 12'd200;
    applyStimulus(12'd0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      applyStimulus((k == 19) ? 12'd250 : DW'(k), 1'b0, 1'b0, 1'b0);
      #1;
      if (k == 19) checkOutput("t3_trig_waddr", {28'd0, buf_waddr}, 3);
      tick();
    end
    checkOutput("t3_readout_we", {31'd0, buf_we}, 0);
    checkOutput("t3_busy", {31'd0, busy}, 1);
    checkOutput("t3_trig_addr", {28'd0, trig_addr}, 3);
    checkOutput("t3_first_raddr", {28'd0, buf_raddr}, 4);
    collectStream(100);
    for (int i = 0; i < 15; i++) exp_data[i] = 4 + i;
    exp_data[15] = 250;
    checkStream("t3");

    // Falling trigger with long wait, then arm-ignored and abort in POST.
    pretrig_len  = 4'd2;
    trig_level   = 12'd50;
    trig_falling = 1'b1;
    applyStimulus(12'd80, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(12'd80, 1'b0, 1'b0, 1'b0);
      #1;
      if (k == 15) checkOutput("t4_addr15", {28'd0, buf_waddr}, 15);
      if (k == 16) checkOutput("t4_wrap1", {28'd0, buf_waddr}, 0);
      if (k == 32) checkOutput("t4_wrap2", {28'd0, buf_waddr}, 0);
      tick();
    end
    checkOutput("t4_busy", {31'd0, busy}, 1);
    checkOutput("t4_still_writing", {31'd0, buf_we}, 1);
    applyStimulus(12'd40, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t4_trig_waddr", {28'd0, buf_waddr}, 8);
    tick();
    checkOutput("t4_trig_addr", {28'd0, trig_addr}, 8);
    applyStimulus(12'd41, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(12'd42, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_arm_ign_waddr", {28'd0, buf_waddr}, 10);
    checkOutput("t6_arm_ign_busy", {31'd0, busy}, 1);
    checkOutput("t6_arm_ign_we", {31'd0, buf_we}, 1);
    applyStimulus(12'd43, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(12'd44, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_abort_we", {31'd0, buf_we}, 0);
    checkOutput("t6_abort_busy", {31'd0, busy}, 0);
    checkOutput("t6_abort_done", {31'd0, done}, 0);
    checkOutput("t6_abort_valid", {31'd0, out_valid}, 0);

    // Asynchronous reset while a sample is held in readout.
    pretrig_len  = 4'd3;
    trig_falling = 1'b0;
    out_ready    = 1'b0;
    applyStimulus(12'd0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(DW'(9 + k), 1'b0, (k == 3), 1'b0);
      tick();
    end
    checkOutput("t6_trig_addr", {28'd0, trig_addr}, 3);
    waitValid("t6_valid");
    checkOutput("t6_first", {20'd0, out_data}, 9);
    #3;
    reset = 1'b1;
    #1;
    checkAllZero("t6_async");
    @(posedge adc_clock);
    #1;
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
- Sequences triggered ADC captures into the 2^ADDR_WIDTH-entry capture buffer. Drives the buffer write and read ports.
- Flow: arm, fill a programmable pre-trigger window, wait for a level-crossing or software trigger, fill the post-trigger window, then stream the whole capture out in time order over a valid/ready interface.
- Sits between the ADC data path and the buffer. The downstream processor or debug logic consumes the stream.

Parameters:
- DATA_WIDTH, 12, ADC sample width.
- ADDR_WIDTH, 12, buffer address width; DEPTH = 2^ADDR_WIDTH samples.

Ports:
- adc_clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- arm  in  1  start a capture; honoured only in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- trig_level  in  DATA_WIDTH  unsigned trigger threshold.
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- sw_trigger  in  1  forced trigger; honoured only in ARMED.
- pretrig_len  in  ADDR_WIDTH  P, number of samples kept before the trigger sample (0..DEPTH-1).
- adc_data  in  DATA_WIDTH  sample, one per clock.
- buf_we  out  1  buffer write enable.
- buf_waddr  out  ADDR_WIDTH  buffer write address.
- buf_wdata  out  DATA_WIDTH  buffer write data.
- buf_raddr  out  ADDR_WIDTH  buffer read address.
- buf_rdata  in  DATA_WIDTH  buffer read data; valid one cycle after buf_raddr.
- out_data  out  DATA_WIDTH  streamed sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the sample.
- out_last  out  1  marks the final (DEPTH-th) sample.
- trig_addr  out  ADDR_WIDTH  buffer address of the trigger sample.
- busy  out  1  high in PRE, ARMED, POST and READOUT.
- done  out  1  high in DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; wptr 0.
- States: IDLE, PRE, ARMED, POST, READOUT, DONE.
- abort has highest priority. From any state it moves to IDLE on the next edge, clearing buf_we, out_valid, out_last, busy and done.

Write path (PRE, ARMED, POST):
- buf_we = 1 in these states only.
- buf_waddr = wptr; buf_wdata = adc_data (combinational pass-through).
- wptr increments each cycle modulo DEPTH.

IDLE/DONE + arm:
- Latch P, trig_level and trig_falling into internal registers.
- wptr <= 0; prev-valid flag cleared; enter PRE, or ARMED if P == 0.

PRE:
- Counts P writes, then enters ARMED.
- Triggers are ignored in PRE.
- prev <= adc_data every write cycle.

ARMED:
- Rising trigger: prev < level and adc_data >= level.
- Falling trigger: prev > level and adc_data <= level.
- Level crossings require prev-valid; sw_trigger does not.
- On trigger: the current sample is written at wptr; trig_addr <= wptr; post count = DEPTH-1-P.
- Next state is POST, or READOUT if the post count is 0.
- With no trigger, wptr wraps indefinitely, overwriting the oldest samples.

POST:
- Writes samples until the post count is exhausted, then enters READOUT.
- The buffer then holds exactly DEPTH samples: P pre-trigger, the trigger sample, and DEPTH-1-P post-trigger.

READOUT:
- rptr starts at trig_addr - P (mod DEPTH).
- Each sample: drive buf_raddr = rptr; one cycle later register buf_rdata into out_data and assert out_valid.
- out_data and out_valid hold stable until out_ready is sampled high.
- On acceptance, rptr++ (mod DEPTH) and issue the next read. Throughput is one sample per 2 cycles minimum.
- out_last is high together with out_valid on the DEPTH-th sample.
- Acceptance of the last sample leads to DONE.

Other rules:
- DONE: done = 1, held until arm (direct to PRE/ARMED) or abort.
- arm while busy is ignored.
- The trigger comparison is unsigned, at DATA_WIDTH.

Test Plan:
1. ADDR_WIDTH=4, P=4, rising, level=100, adc_data ramp 0,10,20,… from the first PRE cycle -> trigger at sample 100; trig_addr=10; 16 samples streamed 60,70,…,210; out_last on 210; done=1.
2. P=0, sw_trigger on the first ARMED cycle with adc_data=7 -> trig_addr=0; the first streamed sample is 7; 15 post samples follow.
3. P=15, level crossing at wptr=3 -> enters READOUT the cycle after the trigger; the trigger sample is streamed last with out_last=1; the first sample is read from address 4.
4. Falling, level=50, adc_data constant 80 for 40 cycles -> no trigger; buf_waddr wraps 15→0 twice; busy=1; then data 40 -> trigger.
5. READOUT with out_ready low for 5 cycles -> out_valid=1 and out_data unchanged throughout; the sample is accepted on the first ready cycle.
6. abort in mid-POST -> IDLE next cycle with buf_we=0, busy=0, done=0. arm pulsed during a subsequent POST is ignored (state stays POST). Asynchronous reset mid-READOUT -> all outputs 0 immediately.
